// File: rtl/hazard_ctrl_pkg.sv
// Shared control-word bit positions, widths and controller state encoding
// for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 10;
  localparam int REG_W  = 5;

  localparam int CTRL_JUMP     = 9;
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_use_cmp.sv
// Combinational load-use detector: the load in EX writes a register the ID
// instruction actually reads (register 0 never creates a hazard).
module load_use_cmp #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = rs_used && (ex_dest == rs_id);
  assign rt_hit = rt_used && (ex_dest == rt_id);
  assign lu     = ex_memread && (ex_dest != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: stage enables, flush and bubble are combinational.
// Optional HAZARD_STATS_EN adds stall/flush/freeze event counters.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 10,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic [REG_W-1:0]  rs_id,
  input  logic [REG_W-1:0]  rt_id,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              branch_taken_ex,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              bubble,
  output logic              mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       freeze_cnt
`endif
);

  import pipe_ctrl_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_dest;
  logic             freeze;
  logic             lu;
  logic             stall_act;
  logic             flush_act;

  assign freeze = dmem_req && !dmem_ready;

  load_use_cmp #(
    .REG_W (REG_W)
  ) u_lu (
    .ex_memread (ex_memread),
    .ex_dest    (ex_dest),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .rs_used    (rs_used),
    .rt_used    (rt_used),
    .lu         (lu)
  );

  // Priority chain; a hazard seen under freeze is not acted on and gets re-evaluated.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    ifid_flush = 1'b0;
    bubble     = 1'b0;
    stall_act  = 1'b0;
    flush_act  = 1'b0;
    if (reset) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
      memwb_we   = 1'b0;
      ifid_flush = 1'b1;
      bubble     = 1'b1;
    end else if (freeze) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
      memwb_we   = 1'b0;
    end else if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      bubble     = 1'b1;
      flush_act  = 1'b1;
    end else if (lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      bubble     = 1'b1;
      stall_act  = 1'b1;
    end else if (ctrl_id[CTRL_JUMP]) begin
      ifid_flush = 1'b1;
      flush_act  = 1'b1;
    end
    ctrl_ex = bubble ? '0 : ctrl_id;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (freeze)     state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_nxt = RUN;
      default:                  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      ex_memread  <= 1'b0;
      ex_dest     <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idex_we) begin
        ex_memread <= ctrl_ex[CTRL_MEMREAD];
        ex_dest    <= rt_id;
      end
      if (state == RUN && state_nxt == MEM_WAIT) begin
        wait_cnt <= '0;
      end else if (state == MEM_WAIT && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == MEM_WAIT && wait_cnt == WAIT_MAX) begin
        mem_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_act) stall_cnt  <= stall_cnt + 32'd1;
      if (flush_act) flush_cnt  <= flush_cnt + 32'd1;
      if (freeze)    freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected outputs are queued per cycle
// and checked by an independent monitor on the falling edge.
module tb_hazard_ctrl;

  localparam logic [9:0] LW  = 10'h0F0;
  localparam logic [9:0] RT  = 10'h122;
  localparam logic [9:0] JMP = 10'h200;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] ctrl_id;
  logic [4:0] rs_id, rt_id;
  logic       rs_used, rt_used, branch_taken_ex, dmem_req, dmem_ready;
  logic [9:0] ctrl_ex;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, bubble, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .ctrl_id         (ctrl_id),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .rs_used         (rs_used),
    .rt_used         (rt_used),
    .branch_taken_ex (branch_taken_ex),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .ctrl_ex         (ctrl_ex),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .idex_we         (idex_we),
    .exmem_we        (exmem_we),
    .memwb_we        (memwb_we),
    .ifid_flush      (ifid_flush),
    .bubble          (bubble),
    .mem_timeout     (mem_timeout)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .freeze_cnt      (freeze_cnt)
`endif
  );

  typedef struct {
    int          id;
    logic [17:0] bits;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec    = 0;
  logic [17:0] got;

  // One cycle of stimulus plus its expected outputs
  // {pc, ifid, idex, exmem, memwb, flush, bubble, ctrl_ex, timeout}.
  task automatic drive(input logic rst, input logic [9:0] c,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic br, input logic req, input logic rdy,
                       input logic e_pc, input logic e_if, input logic e_rest,
                       input logic e_fl, input logic e_bub,
                       input logic [9:0] e_ctrl, input logic e_to);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ctrl_id = c; rs_id = rs; rs_used = rsu; rt_id = rt; rt_used = rtu;
    branch_taken_ex = br; dmem_req = req; dmem_ready = rdy;
    e.id   = vec;
    e.bits = {e_pc, e_if, e_rest, e_rest, e_rest, e_fl, e_bub, e_ctrl, e_to};
    q.push_back(e);
    vec++;
  endtask

  task automatic run_v(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rtu, input logic to);
    drive(0, c, rs, 1, rt, rtu, 0, 0, 0, 1, 1, 1, 0, 0, c, to);
  endtask

  task automatic stall_v(input logic [4:0] rs, input logic [4:0] rt, input logic req);
    drive(0, RT, rs, 1, rt, 1, 0, req, req, 0, 0, 1, 0, 1, 10'h000, 0);
  endtask

  task automatic freeze_v(input logic [4:0] rs, input logic br, input logic to);
    drive(0, RT, rs, 1, 5'd3, 1, br, 1, 0, 0, 0, 0, 0, 0, RT, to);
  endtask

  task automatic reset_v(input logic req, input logic to);
    drive(1, RT, 5'd2, 1, 5'd2, 1, 1, req, 0, 0, 0, 0, 1, 1, 10'h000, to);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      got = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, bubble, ctrl_ex, mem_timeout};
      n_chk++;
      if (got !== cur.bits) begin
        n_fail++;
        $display("FAIL vec%0d outputs got=%b_%b_%h_%b required=%b_%b_%h_%b", cur.id,
                 got[17:13], got[12:11], got[10:1], got[0],
                 cur.bits[17:13], cur.bits[12:11], cur.bits[10:1], cur.bits[0]);
      end
    end
  end

  initial begin
    reset = 1; ctrl_id = '0; rs_id = '0; rt_id = '0; rs_used = 0; rt_used = 0;
    branch_taken_ex = 0; dmem_req = 0; dmem_ready = 0;
    repeat (2) @(posedge clk);

    reset_v(0, 0);
    // load-use through rs, then one-cycle recovery
    run_v(LW, 5'd1, 5'd2, 1, 0);
    stall_v(5'd2, 5'd3, 0);
    run_v(RT, 5'd2, 5'd3, 1, 0);
    // load into $0 never stalls
    run_v(LW, 5'd1, 5'd0, 1, 0);
    run_v(RT, 5'd0, 5'd0, 1, 0);
    // rt matches but is not read
    run_v(LW, 5'd1, 5'd2, 1, 0);
    run_v(RT, 5'd5, 5'd2, 0, 0);
    // load-use through rt
    run_v(LW, 5'd1, 5'd2, 1, 0);
    stall_v(5'd7, 5'd2, 0);
    // taken branch overrides load-use
    run_v(LW, 5'd1, 5'd2, 1, 0);
    drive(0, RT, 5'd2, 1, 5'd3, 1, 1, 0, 0, 1, 1, 1, 1, 1, 10'h000, 0);
    // jump: flush IF/ID, no bubble
    drive(0, JMP, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 1, 0, JMP, 0);
    // load-use held under freeze, acted on in the ready cycle
    run_v(LW, 5'd1, 5'd2, 1, 0);
    freeze_v(5'd2, 0, 0);
    freeze_v(5'd2, 0, 0);
    freeze_v(5'd2, 0, 0);
    stall_v(5'd2, 5'd3, 1);
    run_v(RT, 5'd2, 5'd3, 1, 0);
    // clean 3-cycle freeze, all stages advance on the ready cycle
    for (int k = 0; k < 3; k++) freeze_v(5'd9, 0, 0);
    drive(0, RT, 5'd9, 1, 5'd3, 1, 0, 1, 1, 1, 1, 1, 0, 0, RT, 0);
    // branch held under freeze
    freeze_v(5'd9, 1, 0);
    drive(0, RT, 5'd9, 1, 5'd3, 1, 1, 1, 1, 1, 1, 1, 1, 1, 10'h000, 0);
    // 16-cycle wait raises the sticky timeout
    for (int k = 0; k < 16; k++) freeze_v(5'd9, 0, 0);
    drive(0, RT, 5'd9, 1, 5'd3, 1, 0, 1, 1, 1, 1, 1, 0, 0, RT, 0);
    for (int k = 0; k < 3; k++) run_v(RT, 5'd9, 5'd3, 1, 1);
    reset_v(0, 1);
    run_v(RT, 5'd9, 5'd3, 1, 0);
    // reset in the middle of a memory wait
    freeze_v(5'd9, 0, 0);
    freeze_v(5'd9, 0, 0);
    reset_v(1, 0);
    run_v(RT, 5'd9, 5'd3, 1, 0);
`ifdef HAZARD_STATS_EN
    n_chk++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || freeze_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_after_reset got=%0d/%0d/%0d required=0/0/0",
               stall_cnt, flush_cnt, freeze_cnt);
    end
`endif
    run_v(RT, 5'd9, 5'd3, 1, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
